i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C responder (target) side of the team's I2C link, the counterpart of the existing two-byte-register I2C controller.
- Answers a 7-bit address and holds an 8-bit register pointer.
- Write frame is addr+W, reg, hi byte, lo byte; it produces a 16-bit register write strobe.
- Read frame is addr+W, reg, then STOP or repeated START, addr+R; it returns 16 bits from a fabric register port, MSB first.

Parameters:
SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (min 2)
RESET_PTR, 8'h00, register pointer value after reset

Ports:
clk  input  1  system clock, ≥ 8x SCL rate
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low = release SDA, force IDLE
own_address  input  7  target address to match
scl_in  input  1  SCL pad input (target never drives SCL)
sda_in  input  1  SDA pad input
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
reg_addr  output  8  current register pointer
reg_wdata  output  16  {hi byte, lo byte} of last write frame
reg_wr  output  1  one-clk write strobe
reg_rdata  input  16  read data for reg_addr, sampled on reg_rd
reg_rd  output  1  one-clk strobe; reg_rdata captured that cycle
busy  output  1  high from matched address ACK until STOP/mismatch

Behaviour:
- Reset: sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_wdata=0, reg_addr=RESET_PTR, state=IDLE.
  - rst_n is asynchronous; SDA is released immediately.
- Bus events are decoded from synchronized signals:
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
  - Bits are sampled on synchronized scl rising edges.
  - sda_oe changes only on synchronized scl falling edges.
- START/STOP take priority over any state:
  - START -> ADDR with bit_cnt=0.
  - STOP -> IDLE, sda_oe=0, busy=0.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR:
  - Shift in 8 bits MSB first.
  - Match when the upper 7 bits equal own_address: drive ACK (sda_oe=1) for the 9th clock, busy=1.
  - Mismatch -> IGNORE, SDA untouched.
- After ADDR_ACK:
  - R/W=0 -> REG.
  - R/W=1 -> RD_BYTE.
- REG: shift 8 bits into reg_addr at the 8th rise, ACK, -> WR_BYTE with byte_idx=0.
- WR_BYTE/WR_ACK:
  - byte_idx=0 stores the hi byte.
  - byte_idx=1: reg_wdata<={hi,lo} and reg_wr=1 for exactly one clk, on the cycle after the 8th bit's sampled rise. Then ACK.
  - A third or later data byte is ACKed and discarded unless AUTO_INC_EN.
- A STOP/START before the second byte completes gives no reg_wr; a partial hi byte is discarded.
- RD_BYTE:
  - reg_rd pulses on the ACK-bit rise of ADDR_ACK (R/W=1); reg_rdata is latched into the 16-bit tx shift register.
  - From each scl fall, the target drives the bit MSB first: sda_oe = ~bit.
  - After 8 bits it releases SDA and samples the controller's ACK at the 9th rise.
- RD_ACK:
  - Controller ACK (0) after the hi byte -> lo byte.
  - NACK (1) at any point -> IGNORE, SDA released.
  - ACK after the lo byte: re-send from reg_rdata re-sampled at that rise, with a new reg_rd pulse.
- IGNORE: SDA released, wait for START/STOP.
- en low: same as STOP, plus no bus decoding. reg_addr is retained.
- Every ACK drive is released at the scl fall ending the 9th clock, except that a read continues with the first data bit.

Optional Feature:
AUTO_INC_EN
- Defined: reg_addr increments (mod 256, 8'hFF wraps to 8'h00) after each completed 16-bit write (on reg_wr) and after each lo byte read that the controller ACKs. Subsequent word pairs in the same frame target successive registers.
- Undefined: the pointer changes only in REG; extra write bytes are ACKed and dropped; repeated reads return the same register.

Decomposition:
- Package i2c_pkg:
  - Target state encoding.
  - I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_READ=1'b1.
  - Bit-count width constant, shared with the controller.
- Sub-module i2c_bus_monitor: SYNC_STAGES synchronizers for scl/sda. Outputs:
  - scl_rise / scl_fall pulses.
  - start_det / stop_det pulses.
  - Synchronized sda level.
- i2c_target holds the FSM, shifters and register port.

Test Plan:
- Write frame, own_address=7'h42: bytes 0x84, 0x10, 0xAB, 0xCD -> ACK on all four 9th clocks; one reg_wr pulse with reg_addr=0x10, reg_wdata=0xABCD; busy drops after STOP.
- Read frame with reg_rdata=0x1234:
  - Stimulus: 0x84, 0x05, repeated START, 0x85; controller ACKs hi, NACKs lo.
  - Response: reg_rd pulses once with reg_addr=0x05; SDA shows 0x12 then 0x34; SDA released after NACK.
- Address mismatch: 0x86 then 3 bytes -> sda_oe never asserted; no reg_wr; busy stays 0.
- Abort: 0x84, 0x20, 0xAA, then STOP -> no reg_wr; reg_addr=0x20; next START decodes normally.
- rst_n low mid read-bit while sda_oe=1 -> sda_oe=0 immediately; reg_addr=RESET_PTR; no reg_rd after release.
- AUTO_INC_EN: write 0x84, 0xFF, 0x11, 0x22, 0x33, 0x44 -> reg_wr (0xFF, 0x1122) then (0x00, 0x3344); all bytes ACKed.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller/target pair: bus bit constants,
// bit-counter width and the target state encoding.
package i2c_pkg;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  // Wide enough to count the 9 clocks of a byte plus acknowledge.
  localparam int I2C_BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } tgt_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes the SCL/SDA pads into the clk domain and decodes bus events:
// SCL edges, START (SDA falls while SCL high) and STOP (SDA rises while SCL high).
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_prev;
  logic sda_prev;
  logic scl_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda   = sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history stage; an idle bus reads high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer and a 16-bit register port.
// Write frame: addr+W, reg, hi, lo -> one reg_wr strobe.
// Read frame: addr+W, reg, (re)START, addr+R -> 16 bits MSB first from reg_rdata.
// Optional macro AUTO_INC_EN: pointer advances after each completed word
// written or each lo byte read that the controller ACKs.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_PTR   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  own_address,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  input  logic [15:0] reg_rdata,
  output logic        reg_rd,
  output logic        busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda;

  tgt_state_t               state;
  logic [I2C_BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]               rx_shift;
  logic [7:0]               rx_byte;
  logic                     rw_bit;
  logic [1:0]               byte_idx;
  logic [7:0]               hi_byte;
  logic [15:0]              tx_shift;
  logic                     last_bit;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda      (sda)
  );

  // The byte being completed: seven bits already shifted plus the bit on the bus now.
  assign rx_byte  = {rx_shift, sda};
  assign last_bit = (bit_cnt == I2C_BIT_CNT_W'(7));

  // Target FSM: bits are sampled on SCL rises, SDA drive changes on SCL falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rw_bit    <= 1'b0;
      byte_idx  <= 2'd0;
      hi_byte   <= 8'h00;
      tx_shift  <= 16'h0000;
      sda_oe    <= 1'b0;
      reg_addr  <= RESET_PTR;
      reg_wdata <= 16'h0000;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (reg_rd) begin
        tx_shift <= reg_rdata;
      end
`ifdef AUTO_INC_EN
      if (reg_wr) begin
        reg_addr <= reg_addr + 8'd1;
      end
`endif
      if (!en) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end
            if (scl_rise) begin
              rx_shift <= {rx_shift[5:0], sda};
              bit_cnt  <= bit_cnt + I2C_BIT_CNT_W'(1);
              if (last_bit) begin
                bit_cnt <= '0;
                rw_bit  <= sda;
                if (rx_shift == own_address) begin
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe <= ~I2C_ACK;
              busy   <= 1'b1;
            end
            if (scl_rise) begin
              bit_cnt <= '0;
              if (rw_bit == I2C_RW_READ) begin
                reg_rd   <= 1'b1;
                byte_idx <= 2'd0;
                state    <= ST_RD_BYTE;
              end else begin
                state <= ST_REG;
              end
            end
          end

          ST_REG: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end
            if (scl_rise) begin
              rx_shift <= {rx_shift[5:0], sda};
              bit_cnt  <= bit_cnt + I2C_BIT_CNT_W'(1);
              if (last_bit) begin
                bit_cnt  <= '0;
                reg_addr <= rx_byte;
                state    <= ST_REG_ACK;
              end
            end
          end

          ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= ~I2C_ACK;
            end
            if (scl_rise) begin
              bit_cnt <= '0;
              state   <= ST_WR_BYTE;
              if (state == ST_REG_ACK) begin
                byte_idx <= 2'd0;
              end
            end
          end

          ST_WR_BYTE: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end
            if (scl_rise) begin
              rx_shift <= {rx_shift[5:0], sda};
              bit_cnt  <= bit_cnt + I2C_BIT_CNT_W'(1);
              if (last_bit) begin
                bit_cnt <= '0;
                state   <= ST_WR_ACK;
                case (byte_idx)
                  2'd0: begin
                    hi_byte  <= rx_byte;
                    byte_idx <= 2'd1;
                  end
                  2'd1: begin
                    reg_wdata <= {hi_byte, rx_byte};
                    reg_wr    <= 1'b1;
`ifdef AUTO_INC_EN
                    byte_idx  <= 2'd0;
`else
                    byte_idx  <= 2'd2;
`endif
                  end
                  default: begin
                    byte_idx <= byte_idx;
                  end
                endcase
              end
            end
          end

          ST_RD_BYTE: begin
            if (scl_fall) begin
              sda_oe   <= ~tx_shift[15];
              tx_shift <= {tx_shift[14:0], 1'b0};
            end
            if (scl_rise) begin
              bit_cnt <= bit_cnt + I2C_BIT_CNT_W'(1);
              if (last_bit) begin
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end
            if (scl_rise) begin
              if (sda == I2C_NACK) begin
                state <= ST_IGNORE;
              end else if (byte_idx == 2'd0) begin
                byte_idx <= 2'd1;
                state    <= ST_RD_BYTE;
              end else begin
                byte_idx <= 2'd0;
                reg_rd   <= 1'b1;
                state    <= ST_RD_BYTE;
`ifdef AUTO_INC_EN
                reg_addr <= reg_addr + 8'd1;
`endif
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed testbench for i2c_target: drives an open-drain bus model as the
// controller and checks ACKs, read data and the register port strobes.
// Build with AUTO_INC_EN defined to exercise the pointer auto-increment.
module tb_i2c_target;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [6:0]  own_address = 7'h42;
  logic        scl = 1'b1;
  logic        master_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic [15:0] reg_rdata;
  logic        reg_rd;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  int         wr_count = 0;
  int         rd_count = 0;
  int         oe_cycles = 0;
  int         busy_cycles = 0;
  logic [7:0] wr_addr_log [16];
  logic [15:0] wr_data_log [16];
  logic [7:0] rd_addr_last = 8'h00;

  i2c_target #(
    .SYNC_STAGES(2),
    .RESET_PTR  (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .own_address(own_address),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rdata  (reg_rdata),
    .reg_rd     (reg_rd),
    .busy       (busy)
  );

  // Wired-AND open-drain bus and a tiny register file for reads.
  assign sda_line  = master_sda & ~sda_oe;
  assign reg_rdata = (reg_addr == 8'h05) ? 16'h1234 : 16'hDEAD;

  always #5 clk = ~clk;

  // Logs register port strobes and counts driving/busy cycles, away from the clock edge.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_addr_log[wr_count % 16] = reg_addr;
      wr_data_log[wr_count % 16] = reg_wdata;
      wr_count = wr_count + 1;
    end
    if (reg_rd) begin
      rd_addr_last = reg_addr;
      rd_count = rd_count + 1;
    end
    if (sda_oe) oe_cycles = oe_cycles + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_bit(input logic b, output logic line);
    master_sda = b;
    #Q; scl = 1'b1;
    #Q; line = sda_line;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start;
    master_sda = 1'b1;
    #Q; scl = 1'b1;
    #Q; master_sda = 1'b0;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop;
    master_sda = 1'b0;
    #Q; scl = 1'b1;
    #Q; master_sda = 1'b1;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] data, output logic ack);
    logic line;
    for (int i = 7; i >= 0; i--) bus_bit(data[i], line);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] data);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, line);
      data[i] = line;
    end
    bus_bit(ack_bit, line);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #50;
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_reg_wr: got %b expected 0", reg_wr); end
    compared++; if (reg_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_reg_rd: got %b expected 0", reg_rd); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (reg_wdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_wdata: got %h expected 0000", reg_wdata); end
    compared++; if (reg_addr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 00", reg_addr); end
    rst_n = 1'b1;
    #(4*Q);
  endtask

  task automatic test_write;
    logic [7:0] bytes [4] = '{8'h84, 8'h10, 8'hAB, 8'hCD};
    logic ack;
    int base;
    base = wr_count;
    bus_start;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL write_ack[%0d]: got %b expected 0", i, ack); end
    end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    compared++; if (wr_count - base !== 1) begin mismatched++; $display("[TB] FAIL write_count: got %0d expected 1", wr_count - base); end
    compared++; if (wr_addr_log[base % 16] !== 8'h10) begin mismatched++; $display("[TB] FAIL write_addr: got %h expected 10", wr_addr_log[base % 16]); end
    compared++; if (wr_data_log[base % 16] !== 16'hABCD) begin mismatched++; $display("[TB] FAIL write_data: got %h expected abcd", wr_data_log[base % 16]); end
    bus_stop;
    #(2*Q);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_read;
    logic ack;
    logic [7:0] data;
    int base;
    base = rd_count;
    bus_start;
    send_byte(8'h84, ack);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL read_addr_w_ack: got %b expected 0", ack); end
    send_byte(8'h05, ack);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL read_reg_ack: got %b expected 0", ack); end
    bus_start;
    send_byte(8'h85, ack);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL read_addr_r_ack: got %b expected 0", ack); end
    read_byte(1'b0, data);
    compared++; if (data !== 8'h12) begin mismatched++; $display("[TB] FAIL read_hi: got %h expected 12", data); end
    read_byte(1'b1, data);
    compared++; if (data !== 8'h34) begin mismatched++; $display("[TB] FAIL read_lo: got %h expected 34", data); end
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL read_release_after_nack: got %b expected 0", sda_oe); end
    compared++; if (rd_count - base !== 1) begin mismatched++; $display("[TB] FAIL read_rd_count: got %0d expected 1", rd_count - base); end
    compared++; if (rd_addr_last !== 8'h05) begin mismatched++; $display("[TB] FAIL read_rd_addr: got %h expected 05", rd_addr_last); end
    bus_stop;
    #(2*Q);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL read_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_mismatch;
    logic ack;
    int wr_base, oe_base, busy_base;
    wr_base = wr_count;
    oe_base = oe_cycles;
    busy_base = busy_cycles;
    bus_start;
    send_byte(8'h86, ack);
    compared++; if (ack !== 1'b1) begin mismatched++; $display("[TB] FAIL mismatch_addr_nack: got %b expected 1", ack); end
    send_byte(8'h10, ack);
    send_byte(8'h55, ack);
    send_byte(8'h66, ack);
    compared++; if (ack !== 1'b1) begin mismatched++; $display("[TB] FAIL mismatch_data_nack: got %b expected 1", ack); end
    bus_stop;
    #(2*Q);
    compared++; if (oe_cycles - oe_base !== 0) begin mismatched++; $display("[TB] FAIL mismatch_oe_cycles: got %0d expected 0", oe_cycles - oe_base); end
    compared++; if (wr_count - wr_base !== 0) begin mismatched++; $display("[TB] FAIL mismatch_wr_count: got %0d expected 0", wr_count - wr_base); end
    compared++; if (busy_cycles - busy_base !== 0) begin mismatched++; $display("[TB] FAIL mismatch_busy_cycles: got %0d expected 0", busy_cycles - busy_base); end
  endtask

  task automatic test_abort;
    logic ack;
    int wr_base;
    wr_base = wr_count;
    bus_start;
    send_byte(8'h84, ack);
    send_byte(8'h20, ack);
    send_byte(8'hAA, ack);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_hi_ack: got %b expected 0", ack); end
    bus_stop;
    #(2*Q);
    compared++; if (wr_count - wr_base !== 0) begin mismatched++; $display("[TB] FAIL abort_wr_count: got %0d expected 0", wr_count - wr_base); end
    compared++; if (reg_addr !== 8'h20) begin mismatched++; $display("[TB] FAIL abort_reg_addr: got %h expected 20", reg_addr); end
    bus_start;
    send_byte(8'h84, ack);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_next_start_ack: got %b expected 0", ack); end
    bus_stop;
    #(2*Q);
  endtask

  task automatic test_back_to_back_words;
    logic [7:0] bytes [6] = '{8'h84, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    logic ack;
    int base;
    base = wr_count;
    bus_start;
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], ack);
      compared++; if (ack !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ack[%0d]: got %b expected 0", i, ack); end
    end
    bus_stop;
    #(2*Q);
    compared++; if (wr_addr_log[base % 16] !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_addr0: got %h expected ff", wr_addr_log[base % 16]); end
    compared++; if (wr_data_log[base % 16] !== 16'h1122) begin mismatched++; $display("[TB] FAIL b2b_data0: got %h expected 1122", wr_data_log[base % 16]); end
`ifdef AUTO_INC_EN
    compared++; if (wr_count - base !== 2) begin mismatched++; $display("[TB] FAIL b2b_wr_count: got %0d expected 2", wr_count - base); end
    compared++; if (wr_addr_log[(base + 1) % 16] !== 8'h00) begin mismatched++; $display("[TB] FAIL b2b_addr1: got %h expected 00", wr_addr_log[(base + 1) % 16]); end
    compared++; if (wr_data_log[(base + 1) % 16] !== 16'h3344) begin mismatched++; $display("[TB] FAIL b2b_data1: got %h expected 3344", wr_data_log[(base + 1) % 16]); end
    compared++; if (reg_addr !== 8'h01) begin mismatched++; $display("[TB] FAIL b2b_final_addr: got %h expected 01", reg_addr); end
`else
    compared++; if (wr_count - base !== 1) begin mismatched++; $display("[TB] FAIL b2b_wr_count: got %0d expected 1", wr_count - base); end
    compared++; if (reg_addr !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_final_addr: got %h expected ff", reg_addr); end
`endif
  endtask

  task automatic test_reset_mid_read;
    logic ack;
    int rd_base;
    bus_start;
    send_byte(8'h84, ack);
    send_byte(8'h05, ack);
    bus_start;
    send_byte(8'h85, ack);
    compared++; if (sda_oe !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_pre_drive: got %b expected 1", sda_oe); end
    master_sda = 1'b1;
    #(Q/2 + 3);
    rst_n = 1'b0;
    #1;
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_async_release: got %b expected 0", sda_oe); end
    compared++; if (reg_addr !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_reg_addr: got %h expected 00", reg_addr); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    #20;
    rst_n = 1'b1;
    rd_base = rd_count;
    #Q; scl = 1'b1;
    #Q; scl = 1'b0;
    #Q;
    bus_stop;
    #(4*Q);
    compared++; if (rd_count - rd_base !== 0) begin mismatched++; $display("[TB] FAIL rst_no_rd_after: got %0d expected 0", rd_count - rd_base); end
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_oe_after: got %b expected 0", sda_oe); end
  endtask

  initial begin
    $display("[TB] starting i2c_target bench");
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_abort;
    test_back_to_back_words;
    test_reset_mid_read;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
